ss_scan_ctrl: RTL and testbench



---
 rtl/ss_pkg.sv | 13 +
 rtl/ss_scan_ctrl_if.sv | 24 ++
 rtl/ss_decoder.sv | 30 +++
 rtl/ss_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_ss_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ss_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package ss_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {BLANK, ON} phase_e;

  // Active-low anodes: all n digits off.
  function automatic logic [7:0] an_all_off(input int n);
    return 8'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/ss_scan_ctrl_if.sv
// Update handshake and display pins of the scan controller.
interface ss_scan_ctrl_if #(parameter int N_DIGITS = 4);

  logic                    upd_req;
  logic [4*N_DIGITS-1:0]   upd_data;
  logic [N_DIGITS-1:0]     upd_dp;
  logic [N_DIGITS-1:0]     upd_en;
  logic                    lzb_en;
  logic                    upd_ack;
  logic                    upd_pend;
  logic [7:0]              seg;
  logic [N_DIGITS-1:0]     an;

  modport master (
    output upd_req, upd_data, upd_dp, upd_en, lzb_en,
    input  upd_ack, upd_pend, seg, an
  );

  modport slave (
    input  upd_req, upd_data, upd_dp, upd_en, lzb_en,
    output upd_ack, upd_pend, seg, an
  );

endinterface

// File: rtl/ss_decoder.sv
// Hex nibble to active-low segments g..a (no decimal point).
module ss_decoder (
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    case (nib)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/ss_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with blanking between digits
// and frame-aligned application of new display data.
module ss_scan_ctrl
  import ss_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic           clk,
  input  logic           rst_n,
  ss_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIGIT_CYC);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [7:0]          AN_OFF8 = an_all_off(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_OFF8[N_DIGITS-1:0];

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  phase_e                phase_q, phase_d;
  logic [4*N_DIGITS-1:0] disp_data_q, disp_data_d, pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   disp_en_q, disp_en_d, pend_en_q, pend_en_d;
  logic                  pend_q, pend_d, ack_q, ack_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic                  cnt_last, idx_last, frame_end, visible, seen_nz;
  logic [N_DIGITS-1:0]   lzb_mask;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;

  ss_decoder u_dec (.nib(nib), .seg_n(dec_seg));

  assign nib = disp_data_q[{idx_q, 2'b00} +: 4];

  // Scan position; phase is registered alongside cnt so it always matches it.
  always_comb begin
    cnt_last  = (cnt_q == CNT_W'(DIGIT_CYC - 1));
    idx_last  = (idx_q == IDX_W'(N_DIGITS - 1));
    frame_end = cnt_last && idx_last;
    cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (cnt_last) idx_d = idx_last ? '0 : idx_q + 1'b1;
    phase_d   = (cnt_d < CNT_W'(BLANK_CYC)) ? BLANK : ON;
  end

  // Pending data moves to the display only at the frame wrap; a request in
  // that same cycle is captured after the transfer and waits a full frame.
  always_comb begin
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    disp_en_d   = disp_en_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_d      = pend_q;
    ack_d       = 1'b0;
    if (frame_end && pend_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      disp_en_d   = pend_en_q;
      pend_d      = 1'b0;
      ack_d       = 1'b1;
    end
    if (bus.upd_req) begin
      pend_data_d = bus.upd_data;
      pend_dp_d   = bus.upd_dp;
      pend_en_d   = bus.upd_en;
      pend_d      = 1'b1;
    end
  end

  // Leading zeros: a digit is blank when it and every digit above it are zero.
  always_comb begin
    lzb_mask = '0;
    seen_nz  = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      seen_nz     = seen_nz | (disp_data_q[4*i +: 4] != 4'h0);
      lzb_mask[i] = bus.lzb_en && !seen_nz && (i != 0);
    end
  end

  always_comb begin
    visible = (phase_q == ON) && disp_en_q[idx_q] && !lzb_mask[idx_q];
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;
    if (visible) begin
      an_d[idx_q] = 1'b0;
      seg_d       = {~disp_dp_q[idx_q], dec_seg};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      phase_q     <= BLANK;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      disp_en_q   <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      disp_en_q   <= disp_en_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.upd_ack  = ack_q;
  assign bus.upd_pend = pend_q;
  assign bus.an       = an_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Scoreboard bench: each applied frame queues its 32 expected an/seg samples.
module tb_ss_scan_ctrl;

  localparam int N = 4;
  localparam int D = 8;
  localparam int B = 2;
  localparam int FRAME = N * D;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  logic [11:0] exp_q[$];
  logic [6:0]  dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ss_scan_ctrl_if #(.N_DIGITS(N)) bus ();

  ss_scan_ctrl #(.N_DIGITS(N), .DIGIT_CYC(D), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, seg} for slot cycle k of digit d.
  function automatic logic [11:0] exp_slot(input logic [15:0] data, input logic [3:0] dp,
                                           input logic [3:0] en, input logic lzb,
                                           input int d, input int k);
    logic [3:0] nib;
    logic [3:0] an;
    logic       lz;
    if (k < B) return {4'hF, 8'hFF};
    nib = data[4*d +: 4];
    lz  = lzb && (d != 0) && ((data >> (4*d)) == 16'h0);
    if (!en[d] || lz) return {4'hF, 8'hFF};
    an  = ~(4'b0001 << d);
    return {an, ~dp[d], dec_tbl[nib]};
  endfunction

  task automatic push_frame(input logic [15:0] data, input logic [3:0] dp,
                            input logic [3:0] en, input logic lzb);
    for (int d = 0; d < N; d++)
      for (int k = 0; k < D; k++)
        exp_q.push_back(exp_slot(data, dp, en, lzb, d, k));
  endtask

  // Called on a negedge; returns on the negedge after the request was sampled.
  task automatic do_update(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] en);
    bus.upd_req  = 1'b1;
    bus.upd_data = data;
    bus.upd_dp   = dp;
    bus.upd_en   = en;
    @(negedge clk);
    bus.upd_req  = 1'b0;
  endtask

  task automatic wait_ack(input string name, output int waited);
    waited = -1;
    for (int i = 1; i <= FRAME + 8; i++) begin
      @(negedge clk);
      if (bus.upd_ack === 1'b1) begin
        waited = i;
        break;
      end
    end
    compared++;
    if (waited < 0) begin
      mismatched++;
      $display("FAIL %s_ack_timeout: upd_ack not seen within %0d cycles", name, FRAME + 8);
    end
  endtask

  // Starts on the negedge where the new frame's internal position is 0.
  task automatic check_frame(input string name);
    logic [11:0] e;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL %s_queue_empty: slot %0d has no expected entry", name, j - 1);
        return;
      end
      e = exp_q.pop_front();
      if ({bus.an, bus.seg} !== e) begin
        mismatched++;
        $display("FAIL %s_slot%0d: an=%b seg=%h, expected an=%b seg=%h",
                 name, j - 1, bus.an, bus.seg, e[11:8], e[7:0]);
      end
      if (j < FRAME) begin
        compared++;
        if (bus.upd_ack !== 1'b0) begin
          mismatched++;
          $display("FAIL %s_stray_ack%0d: upd_ack=%b expected 0", name, j - 1, bus.upd_ack);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bus.an, bus.seg, bus.upd_ack, bus.upd_pend} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_state: an=%b seg=%h ack=%b pend=%b, expected 1111/ff/0/0",
               bus.an, bus.seg, bus.upd_ack, bus.upd_pend);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      compared++;
      if ({bus.an, bus.seg} !== {4'hF, 8'hFF}) begin
        mismatched++;
        $display("FAIL reset_dark%0d: an=%b seg=%h, expected 1111/ff", i, bus.an, bus.seg);
      end
    end
  endtask

  task automatic test_scan;
    int w;
    do_update(16'h1234, 4'h0, 4'hF);
    compared++;
    if (bus.upd_pend !== 1'b1) begin
      mismatched++;
      $display("FAIL scan_pend: upd_pend=%b expected 1", bus.upd_pend);
    end
    push_frame(16'h1234, 4'h0, 4'hF, 1'b0);
    wait_ack("scan", w);
    compared++;
    if (bus.upd_pend !== 1'b0) begin
      mismatched++;
      $display("FAIL scan_pend_clear: upd_pend=%b expected 0", bus.upd_pend);
    end
    check_frame("scan");
  endtask

  task automatic test_lzb;
    int w;
    bus.lzb_en = 1'b1;
    do_update(16'h0050, 4'h0, 4'hF);
    push_frame(16'h0050, 4'h0, 4'hF, 1'b1);
    wait_ack("lzb", w);
    check_frame("lzb_on");
    bus.lzb_en = 1'b0;
    push_frame(16'h0050, 4'h0, 4'hF, 1'b0);
    check_frame("lzb_off");
  endtask

  task automatic test_last_write;
    int w;
    repeat (11) @(negedge clk);
    do_update(16'hAAAA, 4'h0, 4'hF);
    compared++;
    if (bus.upd_pend !== 1'b1) begin
      mismatched++;
      $display("FAIL lw_pend: upd_pend=%b expected 1", bus.upd_pend);
    end
    @(negedge clk);
    do_update(16'hBBBB, 4'h0, 4'hF);
    push_frame(16'hBBBB, 4'h0, 4'hF, 1'b0);
    wait_ack("lw", w);
    compared++;
    if (w != 18) begin
      mismatched++;
      $display("FAIL lw_ack_time: ack after %0d cycles, expected 18", w);
    end
    check_frame("lw");
  endtask

  task automatic test_back_to_back;
    repeat (5) @(negedge clk);
    do_update(16'h5678, 4'h0, 4'hF);
    repeat (25) @(negedge clk);
    do_update(16'h9ABC, 4'h0, 4'hF);
    compared++;
    if ({bus.upd_ack, bus.upd_pend} !== 2'b11) begin
      mismatched++;
      $display("FAIL b2b_first_ack: ack=%b pend=%b, expected 1/1", bus.upd_ack, bus.upd_pend);
    end
    push_frame(16'h5678, 4'h0, 4'hF, 1'b0);
    check_frame("b2b_old");
    compared++;
    if ({bus.upd_ack, bus.upd_pend} !== 2'b10) begin
      mismatched++;
      $display("FAIL b2b_second_ack: ack=%b pend=%b, expected 1/0", bus.upd_ack, bus.upd_pend);
    end
    push_frame(16'h9ABC, 4'h0, 4'hF, 1'b0);
    check_frame("b2b_new");
  endtask

  task automatic test_dp_en;
    int w;
    do_update(16'h1234, 4'b0100, 4'b1011);
    push_frame(16'h1234, 4'b0100, 4'b1011, 1'b0);
    wait_ack("dpen", w);
    check_frame("dpen");
  endtask

  task automatic test_reset_mid;
    int acks;
    acks = 0;
    do_update(16'h7777, 4'hF, 4'hF);
    compared++;
    if (bus.upd_pend !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_pend: upd_pend=%b expected 1", bus.upd_pend);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.an, bus.seg, bus.upd_pend} !== {4'hF, 8'hFF, 1'b0}) begin
      mismatched++;
      $display("FAIL rmid_state: an=%b seg=%h pend=%b, expected 1111/ff/0",
               bus.an, bus.seg, bus.upd_pend);
    end
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 8; i++) begin
      @(negedge clk);
      if (bus.upd_ack === 1'b1) acks++;
    end
    compared++;
    if (acks != 0 || bus.an !== 4'hF) begin
      mismatched++;
      $display("FAIL rmid_no_ack: acks=%0d an=%b, expected 0 acks and an=1111", acks, bus.an);
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    bus.upd_req  = 1'b0;
    bus.upd_data = '0;
    bus.upd_dp   = '0;
    bus.upd_en   = '0;
    bus.lzb_en   = 1'b0;
    test_reset;
    test_scan;
    test_lzb;
    test_last_write;
    test_back_to_back;
    test_dp_en;
    test_reset_mid;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL leftover_expected: %0d entries never compared", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
